usb_rx_control: RTL and testbench

Receive-side packet controller for the USB full-speed endpoint. It consumes deserialized bytes and end-of-packet strobes from the RX bit decoder, and validates SYNC, PID, and packet length. Data payload bytes are forwarded into the RX FIFO with the trailing CRC bytes stripped. The block reports the packet type, completion, and errors to the AHB-lite slave, mirroring the TX controller on the opposite side of the buffer.

---
 rtl/usb_rx_control.sv | 272 +++++++++++++++++++++++++++
 tb/tb_usb_rx_control.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_control.sv
// ---------------------------------------------------------------------------
// usb_rx_control
//
// Receive-side packet controller for the USB full-speed endpoint. Takes
// deserialized bytes and end-of-packet strobes from the RX bit decoder. It
// checks the SYNC, the PID and the packet length. Data payload bytes go to
// the RX FIFO with the two trailing CRC bytes removed. Packet type,
// completion and errors are reported to the AHB-lite slave.
//
// Optional feature macro: RX_CRC_CHECK_EN
//   defined   -> CRC-16 (reflected, poly 0xA001, init 0xFFFF) is run over
//                every data-packet byte after the PID. A residual other than
//                0xB001 at eop rejects the packet.
//   undefined -> no CRC logic. CRC bytes are stripped without a check.
//
// Ports
//   clk                  system clock
//   rst                  synchronous, active-high reset
//   rx_byte[7:0]         byte from deserializer (LSB = first bit on wire)
//   byte_valid           one-cycle strobe, rx_byte valid
//   eop                  one-cycle strobe, end of packet
//   rx_bit_error         one-cycle strobe, decoder bit-stuff/line error
//   buffer_full          RX FIFO cannot accept a byte
//   rx_packet[2:0]       0 none,1 IN,2 OUT,3 DATA0,4 DATA1,5 ACK,6 NAK,7 STALL
//   rx_data_ready        one-cycle pulse, valid packet complete
//   rx_transfer_active   packet reception in progress
//   rx_error             packet rejected, sticky until next SYNC
//   store_rx_packet_data one-cycle push strobe to RX FIFO
//   rx_packet_data[7:0]  payload byte accompanying the push strobe
//   rx_state_dbg[2:0]    current FSM state encoding (debug observation)
//
// Handshake: the FIFO interface is push-only. A byte is pushed only when
// buffer_full is low at the moment the push falls due. A push that is due
// while buffer_full is high is dropped, and the packet is rejected.
// ---------------------------------------------------------------------------
module usb_rx_control #(
    parameter int MAX_PAYLOAD = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    input  logic       byte_valid,
    input  logic       eop,
    input  logic       rx_bit_error,
    input  logic       buffer_full,
    output logic [2:0] rx_packet,
    output logic       rx_data_ready,
    output logic       rx_transfer_active,
    output logic       rx_error,
    output logic       store_rx_packet_data,
    output logic [7:0] rx_packet_data,
    output logic [2:0] rx_state_dbg
);

    localparam int CW = $clog2(MAX_PAYLOAD + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PID,
        ST_TOK1,
        ST_TOK2,
        ST_TOK_EOP,
        ST_HS_EOP,
        ST_DATA,
        ST_ERR_WAIT
    } state_t;

    state_t state, state_n;

    logic [2:0]    pid_type;     // decoded type of the packet in progress
    logic [7:0]    hold0;        // oldest held data byte
    logic [7:0]    hold1;        // newest held data byte
    logic [1:0]    hold_cnt;
    logic [CW-1:0] push_cnt;

    // Decode of the byte currently on rx_byte, used only in ST_PID
    logic [2:0] pid_dec;
    state_t     pid_next;
    logic       pid_ok;

    // Per-cycle events computed by the next-state logic
    logic sync_acc;
    logic done;
    logic err;
    logic take;   // data byte enters the holding pipeline without a push
    logic push;   // oldest held byte leaves for the FIFO
    logic pid_load;
    logic active_n;
    logic crc_ok;

`ifdef RX_CRC_CHECK_EN
    logic [15:0] crc;

    function automatic logic [15:0] crc16_byte(input logic [15:0] c,
                                               input logic [7:0]  d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction

    assign crc_ok = (crc == 16'hB001);
`else
    assign crc_ok = 1'b1;
`endif

    assign rx_state_dbg = state;

    // PID: low nibble carries the type, high nibble must be its complement
    assign pid_ok = (rx_byte[3:0] == ~rx_byte[7:4]);

    always_comb begin
        pid_dec  = 3'd0;
        pid_next = ST_ERR_WAIT;
        case (rx_byte[3:0])
            4'b1001: begin pid_dec = 3'd1; pid_next = ST_TOK1;   end
            4'b0001: begin pid_dec = 3'd2; pid_next = ST_TOK1;   end
            4'b0011: begin pid_dec = 3'd3; pid_next = ST_DATA;   end
            4'b1011: begin pid_dec = 3'd4; pid_next = ST_DATA;   end
            4'b0010: begin pid_dec = 3'd5; pid_next = ST_HS_EOP; end
            4'b1010: begin pid_dec = 3'd6; pid_next = ST_HS_EOP; end
            4'b1110: begin pid_dec = 3'd7; pid_next = ST_HS_EOP; end
            default: begin pid_dec = 3'd0; pid_next = ST_ERR_WAIT; end
        endcase
    end

    always_comb begin
        state_n  = state;
        sync_acc = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        take     = 1'b0;
        push     = 1'b0;
        pid_load = 1'b0;

        case (state)
            ST_IDLE: begin
                if (byte_valid && rx_byte == 8'h80) begin
                    sync_acc = 1'b1;
                    state_n  = ST_PID;
                end
            end

            // Errors are already reported; only wait for the line to finish
            ST_ERR_WAIT: begin
                if (eop) state_n = ST_IDLE;
            end

            default: begin
                if (rx_bit_error || (byte_valid && eop)) begin
                    err = 1'b1;
                end else begin
                    case (state)
                        ST_PID: begin
                            if (eop) begin
                                err = 1'b1;
                            end else if (byte_valid) begin
                                if (!pid_ok || pid_next == ST_ERR_WAIT) begin
                                    err = 1'b1;
                                end else begin
                                    pid_load = 1'b1;
                                    state_n  = pid_next;
                                end
                            end
                        end
                        ST_TOK1: begin
                            if (eop)             err = 1'b1;
                            else if (byte_valid) state_n = ST_TOK2;
                        end
                        ST_TOK2: begin
                            if (eop)             err = 1'b1;
                            else if (byte_valid) state_n = ST_TOK_EOP;
                        end
                        ST_TOK_EOP, ST_HS_EOP: begin
                            if (eop)             done = 1'b1;
                            else if (byte_valid) err  = 1'b1;
                        end
                        ST_DATA: begin
                            if (eop) begin
                                // The two held bytes are the CRC
                                if (hold_cnt == 2'd2 && crc_ok) done = 1'b1;
                                else                            err  = 1'b1;
                            end else if (byte_valid) begin
                                if (hold_cnt != 2'd2) begin
                                    take = 1'b1;
                                end else if (push_cnt == CW'(MAX_PAYLOAD) ||
                                             buffer_full) begin
                                    err = 1'b1;
                                end else begin
                                    push = 1'b1;
                                end
                            end
                        end
                        default: err = 1'b1;
                    endcase
                end

                // When eop is the triggering event the line is already idle
                if (err)       state_n = eop ? ST_IDLE : ST_ERR_WAIT;
                else if (done) state_n = ST_IDLE;
            end
        endcase

        // Active through the cycle that reports the outcome, low in ERR_WAIT
        active_n = done || err ||
                   (state_n != ST_IDLE && state_n != ST_ERR_WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= ST_IDLE;
            pid_type             <= 3'd0;
            hold0                <= 8'h00;
            hold1                <= 8'h00;
            hold_cnt             <= 2'd0;
            push_cnt             <= '0;
            rx_packet            <= 3'd0;
            rx_data_ready        <= 1'b0;
            rx_transfer_active   <= 1'b0;
            rx_error             <= 1'b0;
            store_rx_packet_data <= 1'b0;
            rx_packet_data       <= 8'h00;
`ifdef RX_CRC_CHECK_EN
            crc                  <= 16'hFFFF;
`endif
        end else begin
            state                <= state_n;
            rx_data_ready        <= done;
            rx_transfer_active   <= active_n;
            store_rx_packet_data <= push;

            if (sync_acc) begin
                rx_error  <= 1'b0;
                rx_packet <= 3'd0;
                hold_cnt  <= 2'd0;
                push_cnt  <= '0;
`ifdef RX_CRC_CHECK_EN
                crc       <= 16'hFFFF;
`endif
            end

            if (pid_load) pid_type <= pid_dec;

            if (take) begin
                if (hold_cnt == 2'd0) hold0 <= rx_byte;
                else                  hold1 <= rx_byte;
                hold_cnt <= hold_cnt + 2'd1;
            end

            if (push) begin
                rx_packet_data <= hold0;
                hold0          <= hold1;
                hold1          <= rx_byte;
                push_cnt       <= push_cnt + CW'(1);
            end

`ifdef RX_CRC_CHECK_EN
            if (take || push) crc <= crc16_byte(crc, rx_byte);
`endif

            if (err) begin
                rx_error  <= 1'b1;
                rx_packet <= 3'd0;
            end else if (done) begin
                rx_packet <= pid_type;
            end
        end
    end

endmodule

// File: tb/tb_usb_rx_control.sv
// ---------------------------------------------------------------------------
// tb_usb_rx_control
//
// Directed bench for usb_rx_control. A packet-level model keeps the bytes
// received since SYNC and derives the expected registered outputs from the
// packet contents each cycle. A compare process checks every output on each
// falling edge. Literal checks after each scenario pin the model.
// ---------------------------------------------------------------------------
module tb_usb_rx_control;

    localparam int MAX_PAYLOAD = 64;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_byte;
    logic       byte_valid, eop, rx_bit_error, buffer_full;
    logic [2:0] rx_packet;
    logic       rx_data_ready, rx_transfer_active, rx_error;
    logic       store_rx_packet_data;
    logic [7:0] rx_packet_data;
    logic [2:0] rx_state_dbg;

    always #5 clk = ~clk;

    usb_rx_control #(.MAX_PAYLOAD(MAX_PAYLOAD)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .rx_byte              (rx_byte),
        .byte_valid           (byte_valid),
        .eop                  (eop),
        .rx_bit_error         (rx_bit_error),
        .buffer_full          (buffer_full),
        .rx_packet            (rx_packet),
        .rx_data_ready        (rx_data_ready),
        .rx_transfer_active   (rx_transfer_active),
        .rx_error             (rx_error),
        .store_rx_packet_data (store_rx_packet_data),
        .rx_packet_data       (rx_packet_data),
        .rx_state_dbg         (rx_state_dbg)
    );

    // ---------------- counters / check ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- helpers ----------------
    function automatic logic [2:0] pid_type(input logic [7:0] b);
        case (b)
            8'h69:   return 3'd1;
            8'hE1:   return 3'd2;
            8'hC3:   return 3'd3;
            8'h4B:   return 3'd4;
            8'hD2:   return 3'd5;
            8'h5A:   return 3'd6;
            8'h1E:   return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [15:0] crc16_upd(input logic [15:0] c,
                                              input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    // ---------------- model ----------------
    logic [7:0] pkt[$];
    int         mode = 0;   // 0 idle, 1 receiving, 2 waiting for eop
    logic [2:0] e_packet = 3'd0;
    logic       e_ready = 1'b0, e_active = 1'b0, e_error = 1'b0, e_store = 1'b0;
    logic [7:0] e_data = 8'h00;

    function automatic logic crc_good();
`ifdef RX_CRC_CHECK_EN
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 1; i < pkt.size(); i++) c = crc16_upd(c, pkt[i]);
        return (c == 16'hB001);
`else
        return 1'b1;
`endif
    endfunction

    always @(posedge clk) begin : model
        logic bad, fin;
        int   n, d;
        e_ready = 1'b0;
        e_store = 1'b0;
        if (rst) begin
            mode = 0; pkt.delete();
            e_packet = 3'd0; e_error = 1'b0; e_active = 1'b0;
        end else begin
            case (mode)
                0: begin
                    e_active = 1'b0;
                    if (byte_valid && rx_byte == 8'h80) begin
                        mode = 1; pkt.delete();
                        e_error = 1'b0; e_packet = 3'd0; e_active = 1'b1;
                    end
                end
                2: begin
                    e_active = 1'b0;
                    if (eop) mode = 0;
                end
                default: begin
                    bad = 1'b0; fin = 1'b0;
                    if (rx_bit_error || (byte_valid && eop)) begin
                        bad = 1'b1;
                    end else if (eop) begin
                        n = pkt.size();
                        if (n == 0) bad = 1'b1;
                        else case (pid_type(pkt[0]))
                            3'd1, 3'd2:       if (n == 3) fin = 1'b1; else bad = 1'b1;
                            3'd5, 3'd6, 3'd7: if (n == 1) fin = 1'b1; else bad = 1'b1;
                            3'd3, 3'd4:       if (n >= 3 && crc_good()) fin = 1'b1;
                                              else bad = 1'b1;
                            default:          bad = 1'b1;
                        endcase
                    end else if (byte_valid) begin
                        pkt.push_back(rx_byte);
                        n = pkt.size();
                        if (n == 1) begin
                            if (pid_type(rx_byte) == 3'd0) bad = 1'b1;
                        end else case (pid_type(pkt[0]))
                            3'd1, 3'd2:       if (n > 3) bad = 1'b1;
                            3'd5, 3'd6, 3'd7: bad = 1'b1;
                            default: begin
                                d = n - 1;  // data bytes received
                                if (d >= 3) begin
                                    // push number d-2 carries data byte d-2
                                    if (d - 2 > MAX_PAYLOAD || buffer_full) bad = 1'b1;
                                    else begin e_store = 1'b1; e_data = pkt[d-2]; end
                                end
                            end
                        endcase
                    end
                    e_active = 1'b1;
                    if (bad) begin
                        e_error = 1'b1; e_packet = 3'd0; e_store = 1'b0;
                        mode = eop ? 0 : 2;
                    end else if (fin) begin
                        e_packet = pid_type(pkt[0]); e_ready = 1'b1; mode = 0;
                    end
                end
            endcase
        end
    end

    // ---------------- compare / monitor ----------------
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_rx_packet", rx_packet, e_packet);
            check("cyc_rx_data_ready", rx_data_ready, e_ready);
            check("cyc_rx_transfer_active", rx_transfer_active, e_active);
            check("cyc_rx_error", rx_error, e_error);
            check("cyc_store", store_rx_packet_data, e_store);
            if (e_store) check("cyc_rx_packet_data", rx_packet_data, e_data);
            if (store_rx_packet_data === 1'b1) got_q.push_back(rx_packet_data);
        end
    end

    task automatic check_pushes(input string name);
        check({name, "_push_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({name, "_push_byte"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input logic bv, input logic [7:0] b, input logic e,
                         input logic be, input logic bf);
        byte_valid = bv; rx_byte = b; eop = e; rx_bit_error = be; buffer_full = bf;
        @(posedge clk); #1;
        byte_valid = 1'b0; eop = 1'b0; rx_bit_error = 1'b0; buffer_full = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        drive(1'b1, b, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_eop();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_packet"}, rx_packet, 3'd0);
        check({name, "_ready"}, rx_data_ready, 1'b0);
        check({name, "_active"}, rx_transfer_active, 1'b0);
        check({name, "_error"}, rx_error, 1'b0);
        check({name, "_store"}, store_rx_packet_data, 1'b0);
        check({name, "_data"}, rx_packet_data, 8'h00);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] c;
        logic [7:0]  b;
        rst = 1'b1; rx_byte = 8'h00; byte_valid = 1'b0; eop = 1'b0;
        rx_bit_error = 1'b0; buffer_full = 1'b0;
        @(posedge clk); #1;
        cmp_en = 1'b1;
        idle(1);
        check_all_zero("reset");
        rst = 1'b0;
        idle(2);

        // Minimum data packet, zero payload
        send(8'h80); send(8'hC3); send(8'h00); send(8'h00); send_eop();
        check("min_data_packet", rx_packet, 3'd3);
        check("min_data_ready", rx_data_ready, 1'b1);
        check("min_data_error", rx_error, 1'b0);
        check("min_data_active", rx_transfer_active, 1'b1);
        idle(1);
        check("min_data_ready_drop", rx_data_ready, 1'b0);
        check("min_data_active_drop", rx_transfer_active, 1'b0);
        check("min_data_packet_hold", rx_packet, 3'd3);
        check_pushes("min_data");

        // DATA1 with two payload bytes
        send(8'h80); send(8'h4B); send(8'h11); send(8'h22); send(8'h33);
        check("data1_first_push", rx_packet_data, 8'h11);
        send(8'h44); send_eop();
`ifndef RX_CRC_CHECK_EN
        check("data1_packet", rx_packet, 3'd4);
        check("data1_error", rx_error, 1'b0);
`endif
        exp_q = '{8'h11, 8'h22};
        idle(1);
        check_pushes("data1");

        // ACK, then ACK followed by an unexpected byte
        send(8'h80); send(8'hD2); send_eop();
        check("ack_packet", rx_packet, 3'd5);
        check("ack_ready", rx_data_ready, 1'b1);
        idle(1);
        send(8'h80);
        check("sync_clears_packet", rx_packet, 3'd0);
        send(8'hD2); send(8'h55);
        check("ack_extra_error", rx_error, 1'b1);
        check("ack_extra_packet", rx_packet, 3'd0);
        check("ack_extra_active", rx_transfer_active, 1'b1);
        idle(1);
        check("errwait_active_low", rx_transfer_active, 1'b0);
        send_eop();
        check("ack_extra_no_ready", rx_data_ready, 1'b0);
        check("ack_extra_sticky", rx_error, 1'b1);
        idle(1);

        // Overflow: MAX_PAYLOAD+3 data bytes
        send(8'h80); send(8'hC3);
        for (int i = 0; i < MAX_PAYLOAD + 3; i++) send(8'(i + 1));
        check("overflow_error", rx_error, 1'b1);
        for (int i = 0; i < MAX_PAYLOAD; i++) exp_q.push_back(8'(i + 1));
        send(8'h99);
        check("overflow_errwait_active", rx_transfer_active, 1'b0);
        send_eop(); idle(1);
        check_pushes("overflow");
        send(8'h80);
        check("after_overflow_sync", rx_error, 1'b0);
        send(8'hD2); send_eop();
        check("after_overflow_ack", rx_packet, 3'd5);
        idle(1);

        // Exactly MAX_PAYLOAD payload bytes with a correct CRC
        send(8'h80); send(8'hC3);
        c = 16'hFFFF;
        for (int i = 0; i < MAX_PAYLOAD; i++) begin
            b = 8'(i * 3 + 7);
            c = crc16_upd(c, b);
            exp_q.push_back(b);
            send(b);
        end
        c = ~c;
        send(c[7:0]); send(c[15:8]); send_eop();
        check("max_payload_packet", rx_packet, 3'd3);
        check("max_payload_ready", rx_data_ready, 1'b1);
        idle(1);
        check_pushes("max_payload");

        // Bad PID, stray byte in IDLE, SYNC clears the error
        send(8'h80); send(8'hF1);
        check("bad_pid_error", rx_error, 1'b1);
        send_eop();
        send(8'h7A);
        check("stray_byte_error_kept", rx_error, 1'b1);
        check("stray_byte_inactive", rx_transfer_active, 1'b0);
        send(8'h80);
        check("sync_clears_error", rx_error, 1'b0);
        check("sync_sets_active", rx_transfer_active, 1'b1);
        send(8'h5A); send_eop();
        check("nak_packet", rx_packet, 3'd6);
        idle(1);

        // Reset mid-packet
        send(8'h80); send(8'h69); send(8'h01);
        rst = 1'b1; idle(1);
        check_all_zero("mid_reset");
        rst = 1'b0;
        send(8'h02); send_eop(); idle(1);
        check_all_zero("after_reset_trailing");
        send(8'h80); send(8'hE1); send(8'h05); send(8'h08); send_eop();
        check("out_packet", rx_packet, 3'd2);
        check("out_ready", rx_data_ready, 1'b1);
        idle(1);

        // buffer_full when a push is due
        send(8'h80); send(8'h4B); send(8'hAA); send(8'hBB);
        drive(1'b1, 8'hCC, 1'b0, 1'b0, 1'b1);
        check("bfull_error", rx_error, 1'b1);
        check("bfull_no_push", store_rx_packet_data, 1'b0);
        send_eop(); idle(1);
        check_pushes("bfull");

        // Bit error during data, short data packet, eop in PID
        send(8'h80); send(8'hC3); send(8'h01);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("bit_error", rx_error, 1'b1);
        send_eop();
        send(8'h80); send(8'hC3); send(8'h11); send_eop();
        check("short_data_error", rx_error, 1'b1);
        idle(1);
        send(8'h80); send_eop();
        check("eop_in_pid_error", rx_error, 1'b1);
        idle(1);
        check("eop_in_pid_idle", rx_transfer_active, 1'b0);

        // byte_valid with eop in TOK1 returns straight to IDLE
        send(8'h80); send(8'h69);
        drive(1'b1, 8'h12, 1'b1, 1'b0, 1'b0);
        check("bv_eop_error", rx_error, 1'b1);
        send(8'h80); send(8'h1E); send_eop();
        check("stall_packet", rx_packet, 3'd7);
        check("stall_error_clear", rx_error, 1'b0);

        // Extra token byte
        send(8'h80); send(8'h69); send(8'h01); send(8'h02); send(8'h03);
        check("token_extra_error", rx_error, 1'b1);
        send_eop(); idle(2);
        check_pushes("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
